y86_regfile_sb: RTL
===================

Name: y86_regfile_sb

Overview:
- Parametrised architectural register file for the Y86-64 pipeline; it replaces the fifteen loose value0..value14 buses that decode currently takes in.
- Holds register state internally with two write-back ports (E and M).
- Provides NRP combinational read ports with write-back-stage bypass.
- Keeps a per-register pending-write scoreboard so decode can detect in-flight producers and raise stall requests.
- Sits between decode (read/issue) and write-back (retire).

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 15, number of implemented registers (indices 0..NREGS-1).
- AW, 4, register-index width.
- NRP, 2, number of read ports.
- RNONE, 4'hF, "no register" index.
- RSP_IDX, 4, stack pointer index.
- RSP_INIT, 64'h0, reset value of the stack pointer.
- CW, 2, scoreboard counter width (maximum pending writes = 2^CW-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRP*AW  read indices, port i at bits [i*AW +: AW].
- rd_data  out  NRP*XLEN  read data, port i at bits [i*XLEN +: XLEN].
- rd_busy  out  NRP  port i's register has an outstanding producer not retiring this cycle.
- issue_en  in  1  decode issues an instruction this cycle.
- issue_dstE  in  AW  destination E of the issuing instruction (RNONE = none).
- issue_dstM  in  AW  destination M of the issuing instruction.
- W_dstE  in  AW  write-back port E index.
- W_valE  in  XLEN  write-back port E data.
- W_dstM  in  AW  write-back port M index.
- W_valM  in  XLEN  write-back port M data.
- flush  in  1  pipeline flush (mispredict/exception); clears the scoreboard.
- sb_err  out  1  sticky scoreboard overflow/underflow error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0, except register RSP_IDX, which loads RSP_INIT.
  - All scoreboard counters clear to 0; sb_err clears to 0.
  - Outputs follow immediately: rd_data reflects the reset contents and rd_busy = 0.
- Reset release: the first rising edge with rst_n high performs normal updates.
- Valid index: idx != RNONE and idx < NREGS. Invalid indices are ignored for writes, issues and retires.
- Write: on the rising edge, write W_valE to reg[W_dstE] and W_valM to reg[W_dstM] when each index is valid.
  - If W_dstE == W_dstM, port M wins (popq %rsp semantics).
- Read (combinational, zero latency) for each port i:
  - Invalid rd_addr: rd_data = 0.
  - Else if rd_addr == W_dstM: rd_data = W_valM.
  - Else if rd_addr == W_dstE: rd_data = W_valE.
  - Else: rd_data = reg[rd_addr].
  - Result: a read in the same cycle as a write returns the new value.
- Scoreboard: one CW-bit counter per register.
  - Per rising edge, for register r: inc = (issue_en & issue_dstE==r) + (issue_en & issue_dstM==r), range 0..2.
  - dec = (W_dstE==r) + (W_dstM==r), range 0..2.
  - Next count = cnt + inc - dec.
- Scoreboard boundaries:
  - If next count > 2^CW-1: clamp to 2^CW-1 and set sb_err.
  - If next count < 0: clamp to 0 and set sb_err.
  - sb_err stays set until reset.
- Flush: when flush=1, all counters go to 0 on the edge and the same-cycle issue is discarded. Same-cycle register-file writes still occur, and flush does not set sb_err.
- rd_busy[i] = valid(rd_addr) & (cnt[rd_addr] > dec(rd_addr) of this cycle).
  - Always 0 for RNONE.
  - rd_busy[i] is purely combinational from current state and inputs.
- Multiple read ports may address the same register and return identical data and busy values.
- Implementation: synthesisable RTL, no latches. rd_data and rd_busy must be fully assigned on every path.

Test Plan:
- Reset value: reset with RSP_INIT=64'h100; read ports at 4 and 0 -> rd_data 64'h100 and 0, rd_busy 00, sb_err 0.
- Same-cycle bypass and write: W_dstE=3, W_valE=64'hAA with rd_addr0=3 -> rd_data0=64'hAA in the same cycle; reads 64'hAA next cycle with W_dstE=F.
- Port M priority: W_dstE=W_dstM=4, W_valE=8, W_valM=64'h55 -> reg4=64'h55.
- Scoreboard issue and retire: issue dstE=2 -> next cycle rd_busy for 2 = 1. Retire W_dstE=2 -> busy 0 in the retire cycle and counter 0 after.
- Counter overflow: four issues to reg 5 with CW=2 -> counter clamps at 3 and sb_err=1. Flush -> counters 0, sb_err remains 1.
- Reset mid-operation: drop rst_n with counters nonzero and a pending write -> immediate clear; no write occurs while rst_n is low.

Source files
------------

// File: rtl/y86_regfile_sb.sv
// Y86-64 architectural register file: two write-back ports, NRP bypassed read
// ports and a per-register pending-write scoreboard for decode stall detection.

module y86_rf_rdport #(
    parameter int              XLEN  = 64,
    parameter int              NREGS = 15,
    parameter int              AW    = 4,
    parameter logic [AW-1:0]   RNONE = 4'hF,
    parameter int              CW    = 2
) (
    input  logic [AW-1:0]                  addr,
    input  logic [NREGS-1:0][XLEN-1:0]     regs,
    input  logic [NREGS-1:0][CW-1:0]       cnt,
    input  logic [AW-1:0]                  W_dstE,
    input  logic [XLEN-1:0]                W_valE,
    input  logic [AW-1:0]                  W_dstM,
    input  logic [XLEN-1:0]                W_valM,
    output logic [XLEN-1:0]                data,
    output logic                           busy
);
    logic          valid;
    logic [CW:0]   dec;

    assign valid = (addr != RNONE) && (int'(addr) < NREGS);
    assign dec   = (CW+1)'(addr == W_dstE) + (CW+1)'(addr == W_dstM);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (valid) begin
            // M is checked first so a same-index dual write forwards the winner
            if (addr == W_dstM)      data = W_valM;
            else if (addr == W_dstE) data = W_valE;
            else                     data = regs[addr];
            busy = {1'b0, cnt[addr]} > dec;
        end
    end
endmodule

module y86_regfile_sb #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 15,
    parameter int              AW       = 4,
    parameter int              NRP      = 2,
    parameter logic [AW-1:0]   RNONE    = 4'hF,
    parameter int              RSP_IDX  = 4,
    parameter logic [XLEN-1:0] RSP_INIT = 64'h0,
    parameter int              CW       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRP*AW-1:0]    rd_addr,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP-1:0]       rd_busy,
    input  logic                 issue_en,
    input  logic [AW-1:0]        issue_dstE,
    input  logic [AW-1:0]        issue_dstM,
    input  logic [AW-1:0]        W_dstE,
    input  logic [XLEN-1:0]      W_valE,
    input  logic [AW-1:0]        W_dstM,
    input  logic [XLEN-1:0]      W_valM,
    input  logic                 flush,
    output logic                 sb_err
);
    localparam int CMAX = (2**CW) - 1;
    localparam int SW   = CW + 2;

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0][CW-1:0]   cnt, cnt_nxt;
    logic [NREGS-1:0]           hit_we, hit_wm, over, under;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        localparam logic [AW-1:0] RI = AW'(r);
        localparam bit            OK = (RI != RNONE);
        logic [1:0]    inc, dec;
        logic [SW-1:0] sum;

        assign hit_we[r] = OK && (W_dstE == RI);
        assign hit_wm[r] = OK && (W_dstM == RI);
        assign inc = 2'(issue_en && OK && (issue_dstE == RI))
                   + 2'(issue_en && OK && (issue_dstM == RI));
        assign dec = 2'(hit_we[r]) + 2'(hit_wm[r]);
        // widened signed-ish sum: MSB flags underflow, magnitude flags overflow
        assign sum      = SW'(cnt[r]) + SW'(inc) - SW'(dec);
        assign under[r] = sum[SW-1];
        assign over[r]  = !sum[SW-1] && (sum > SW'(CMAX));
        assign cnt_nxt[r] = under[r] ? '0 : over[r] ? CW'(CMAX) : sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= (r == RSP_IDX) ? RSP_INIT : '0;
            cnt    <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (hit_wm[r])      regs[r] <= W_valM;
                else if (hit_we[r]) regs[r] <= W_valE;
            end
            cnt    <= flush ? '0 : cnt_nxt;
            sb_err <= sb_err | (~flush & (|(over | under)));
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rp
        y86_rf_rdport #(
            .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .RNONE(RNONE), .CW(CW)
        ) u_rp (
            .addr   (rd_addr[p*AW +: AW]),
            .regs   (regs),
            .cnt    (cnt),
            .W_dstE (W_dstE),
            .W_valE (W_valE),
            .W_dstM (W_dstM),
            .W_valM (W_valM),
            .data   (rd_data[p*XLEN +: XLEN]),
            .busy   (rd_busy[p])
        );
    end
endmodule
